// File: rtl/pipeline_stage_regs.sv
// Stage-register bank for the 5-stage MIPS pipeline: IF/ID/EXE/MEM/WB
// valid flags, forwarding feedback, PC/instruction carry and counters.
module pipeline_stage_regs #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_rst,
    input  logic              id_rst,
    input  logic              exe_rst,
    input  logic              mem_rst,
    input  logic              wb_rst,
    input  logic              if_en,
    input  logic              id_en,
    input  logic              exe_en,
    input  logic              mem_en,
    input  logic              wb_en,
    output logic              if_valid,
    output logic              id_valid,
    output logic              exe_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    input  logic [ADDR_W-1:0] pc_if,
    input  logic [31:0]       inst_if,
    output logic [ADDR_W-1:0] pc_id,
    output logic [31:0]       inst_id,
    input  logic              wb_wen_id,
    input  logic [4:0]        wb_addr_id,
    input  logic              mem_ren_id,
    input  logic              mem_wen_id,
    input  logic              is_load_id,
    input  logic              is_branch_id,
    output logic [4:0]        regw_addr_exe,
    output logic              wb_wen_exe,
    output logic              mem_ren_exe,
    output logic              is_load_exe,
    output logic              is_branch_exe,
    output logic              mem_wen_exe,
    output logic [4:0]        regw_addr_mem,
    output logic              wb_wen_mem,
    output logic              mem_ren_mem,
    output logic              mem_wen_mem,
    output logic              is_branch_mem,
    output logic [4:0]        regw_addr_wb,
    output logic              wb_wen_wb,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
        end else if (if_rst) begin
            if_valid <= 1'b0;
        end else if (if_en) begin
            if_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            pc_id    <= '0;
            inst_id  <= '0;
        end else if (id_rst) begin
            id_valid <= 1'b0;
            pc_id    <= '0;
            inst_id  <= '0;
        end else if (id_en) begin
            id_valid <= if_valid;
            pc_id    <= pc_if;
            inst_id  <= inst_if;
        end
    end

    // Flags are gated by id_valid so a bubble can never raise a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_valid     <= 1'b0;
            regw_addr_exe <= '0;
            wb_wen_exe    <= 1'b0;
            mem_ren_exe   <= 1'b0;
            mem_wen_exe   <= 1'b0;
            is_load_exe   <= 1'b0;
            is_branch_exe <= 1'b0;
        end else if (exe_rst) begin
            exe_valid     <= 1'b0;
            regw_addr_exe <= '0;
            wb_wen_exe    <= 1'b0;
            mem_ren_exe   <= 1'b0;
            mem_wen_exe   <= 1'b0;
            is_load_exe   <= 1'b0;
            is_branch_exe <= 1'b0;
        end else if (exe_en) begin
            exe_valid     <= id_valid;
            regw_addr_exe <= wb_addr_id;
            wb_wen_exe    <= wb_wen_id & id_valid;
            mem_ren_exe   <= mem_ren_id & id_valid;
            mem_wen_exe   <= mem_wen_id & id_valid;
            is_load_exe   <= is_load_id & id_valid;
            is_branch_exe <= is_branch_id & id_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid     <= 1'b0;
            regw_addr_mem <= '0;
            wb_wen_mem    <= 1'b0;
            mem_ren_mem   <= 1'b0;
            mem_wen_mem   <= 1'b0;
            is_branch_mem <= 1'b0;
        end else if (mem_rst) begin
            mem_valid     <= 1'b0;
            regw_addr_mem <= '0;
            wb_wen_mem    <= 1'b0;
            mem_ren_mem   <= 1'b0;
            mem_wen_mem   <= 1'b0;
            is_branch_mem <= 1'b0;
        end else if (mem_en) begin
            mem_valid     <= exe_valid;
            regw_addr_mem <= regw_addr_exe;
            wb_wen_mem    <= wb_wen_exe;
            mem_ren_mem   <= mem_ren_exe;
            mem_wen_mem   <= mem_wen_exe;
            is_branch_mem <= is_branch_exe;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            regw_addr_wb <= '0;
            wb_wen_wb    <= 1'b0;
        end else if (wb_rst) begin
            wb_valid     <= 1'b0;
            regw_addr_wb <= '0;
            wb_wen_wb    <= 1'b0;
        end else if (wb_en) begin
            wb_valid     <= mem_valid;
            regw_addr_wb <= regw_addr_mem;
            wb_wen_wb    <= wb_wen_mem;
        end
    end

    // A load stall is the controller freezing IF while flushing ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (wb_valid && wb_en && !wb_rst) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
            if (!if_en && id_rst) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Self-checking bench for pipeline_stage_regs: directed scenarios plus
// random traffic against an array-of-stages reference model.
module tb_pipeline_stage_regs;

    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic        clk;
    logic        rst;
    logic [4:0]  en;
    logic [4:0]  srst;
    logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic [31:0] pc_if, inst_if, pc_id, inst_id;
    logic        wb_wen_id, mem_ren_id, mem_wen_id, is_load_id, is_branch_id;
    logic [4:0]  wb_addr_id;
    logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic        wb_wen_exe, mem_ren_exe, is_load_exe, is_branch_exe, mem_wen_exe;
    logic        wb_wen_mem, mem_ren_mem, mem_wen_mem, is_branch_mem;
    logic        wb_wen_wb;
    logic [CW-1:0] retire_cnt, stall_cnt;

    pipeline_stage_regs #(.ADDR_W(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_rst(srst[0]), .id_rst(srst[1]), .exe_rst(srst[2]),
        .mem_rst(srst[3]), .wb_rst(srst[4]),
        .if_en(en[0]), .id_en(en[1]), .exe_en(en[2]),
        .mem_en(en[3]), .wb_en(en[4]),
        .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .pc_if(pc_if), .inst_if(inst_if), .pc_id(pc_id), .inst_id(inst_id),
        .wb_wen_id(wb_wen_id), .wb_addr_id(wb_addr_id),
        .mem_ren_id(mem_ren_id), .mem_wen_id(mem_wen_id),
        .is_load_id(is_load_id), .is_branch_id(is_branch_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .mem_ren_exe(mem_ren_exe), .is_load_exe(is_load_exe),
        .is_branch_exe(is_branch_exe), .mem_wen_exe(mem_wen_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
        .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
        .is_branch_mem(is_branch_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  a;
        logic        w, r, m, l, b;
    } st_t;

    st_t ms [5];
    int  mret, mstall;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int s = 0; s < 5; s++) ms[s] = '0;
        mret   = 0;
        mstall = 0;
    endtask

    // One clock of the pipeline: each stage flushes, loads or holds.
    task automatic model_edge();
        st_t nx [5];
        st_t inc;
        for (int s = 0; s < 5; s++) begin
            inc = '0;
            case (s)
                0: inc.v = 1'b1;
                1: begin
                    inc.v    = ms[0].v;
                    inc.pc   = pc_if;
                    inc.inst = inst_if;
                end
                2: begin
                    inc.v = ms[1].v;
                    inc.a = wb_addr_id;
                    inc.w = wb_wen_id;
                    inc.r = mem_ren_id;
                    inc.m = mem_wen_id;
                    inc.l = is_load_id;
                    inc.b = is_branch_id;
                end
                default: inc = ms[s-1];
            endcase
            if (s >= 2) begin
                inc.w = inc.w & inc.v;
                inc.r = inc.r & inc.v;
                inc.m = inc.m & inc.v;
                inc.l = inc.l & inc.v;
                inc.b = inc.b & inc.v;
            end
            if (srst[s]) nx[s] = '0;
            else if (en[s]) nx[s] = inc;
            else nx[s] = ms[s];
        end
        if (ms[4].v && en[4] && !srst[4]) mret = (mret + 1) % MOD;
        if (!en[0] && srst[1]) mstall = (mstall + 1) % MOD;
        for (int s = 0; s < 5; s++) ms[s] = nx[s];
    endtask

    task automatic check_all();
        chk("if_valid", if_valid, ms[0].v);
        chk("id_valid", id_valid, ms[1].v);
        chk("exe_valid", exe_valid, ms[2].v);
        chk("mem_valid", mem_valid, ms[3].v);
        chk("wb_valid", wb_valid, ms[4].v);
        chk("pc_id", pc_id, ms[1].pc);
        chk("inst_id", inst_id, ms[1].inst);
        chk("regw_addr_exe", regw_addr_exe, ms[2].a);
        chk("wb_wen_exe", wb_wen_exe, ms[2].w);
        chk("mem_ren_exe", mem_ren_exe, ms[2].r);
        chk("mem_wen_exe", mem_wen_exe, ms[2].m);
        chk("is_load_exe", is_load_exe, ms[2].l);
        chk("is_branch_exe", is_branch_exe, ms[2].b);
        chk("regw_addr_mem", regw_addr_mem, ms[3].a);
        chk("wb_wen_mem", wb_wen_mem, ms[3].w);
        chk("mem_ren_mem", mem_ren_mem, ms[3].r);
        chk("mem_wen_mem", mem_wen_mem, ms[3].m);
        chk("is_branch_mem", is_branch_mem, ms[3].b);
        chk("regw_addr_wb", regw_addr_wb, ms[4].a);
        chk("wb_wen_wb", wb_wen_wb, ms[4].w);
        chk("retire_cnt", retire_cnt, 64'(mret));
        chk("stall_cnt", stall_cnt, 64'(mstall));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) mreset();
        else model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Decoder stand-in: inst[8]=wen, [7]=branch, [6]=store, [5]=load, [4:0]=rd.
    task automatic drive_decode();
        wb_wen_id    = ms[1].inst[8];
        is_branch_id = ms[1].inst[7];
        mem_wen_id   = ms[1].inst[6];
        mem_ren_id   = ms[1].inst[5];
        is_load_id   = ms[1].inst[5];
        wb_addr_id   = ms[1].inst[4:0];
    endtask

    task automatic drive_random();
        pc_if        = $urandom;
        inst_if      = $urandom;
        wb_wen_id    = 1'($urandom);
        wb_addr_id   = 5'($urandom);
        mem_ren_id   = 1'($urandom);
        mem_wen_id   = 1'($urandom);
        is_load_id   = 1'($urandom);
        is_branch_id = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        mreset();
        check_all();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_ret, exp_stall;
        rst  = 1'b1;
        en   = '0;
        srst = '0;
        pc_if = '0;
        inst_if = '0;
        wb_wen_id = 0; wb_addr_id = '0; mem_ren_id = 0;
        mem_wen_id = 0; is_load_id = 0; is_branch_id = 0;
        mreset();
        #1;
        check_all();
        step();
        rst = 1'b0;

        // Five ADDs to r8..r12, then IF is flushed so nothing is duplicated.
        for (int n = 1; n <= 12; n++) begin
            en      = '1;
            srst    = (n >= 6) ? 5'b00001 : 5'b00000;
            pc_if   = 32'(n * 4);
            inst_if = {23'h0, 1'b1, 3'b000, 5'(n + 6)};
            drive_decode();
            step();
            if (n == 2) chk("flow_inst_id", inst_id, 32'h108);
            if (n == 3) chk("flow_exe_addr", regw_addr_exe, 8);
            if (n == 5) chk("flow_wb_addr", regw_addr_wb, 8);
            if (n == 12) chk("flow_retire", retire_cnt, 5);
        end

        // LW r8 followed by ADD r9: one-cycle load stall.
        do_reset();
        en = '1;
        srst = '0;
        step();
        inst_if = 32'h128;
        drive_decode();
        step();
        inst_if = 32'h109;
        en[0] = 1'b0;
        srst[1] = 1'b1;
        drive_decode();
        step();
        en = '1;
        srst = '0;
        drive_decode();
        step();
        chk("stall_exe_valid", exe_valid, 0);
        chk("stall_exe_wen", wb_wen_exe, 0);
        chk("stall_mem_load", mem_ren_mem, 1);
        chk("stall_inst_id", inst_id, 32'h109);
        chk("stall_cnt_one", stall_cnt, 1);
        drive_decode();
        step();
        chk("stall_add_exe", regw_addr_exe, 9);
        chk("stall_add_valid", exe_valid, 1);

        // Flush beats enable in ID.
        srst = 5'b00010;
        drive_decode();
        step();
        chk("flush_id_valid", id_valid, 0);
        chk("flush_inst_id", inst_id, 0);
        srst = '0;

        // Debug freeze: input noise must not disturb anything.
        exp_ret   = mret;
        exp_stall = mstall;
        en = '0;
        for (int i = 0; i < 10; i++) begin
            drive_random();
            step();
        end
        chk("freeze_retire", retire_cnt, 64'(exp_ret));
        chk("freeze_stall", stall_cnt, 64'(exp_stall));

        // Random enables, flushes and data.
        for (int i = 0; i < 300; i++) begin
            for (int s = 0; s < 5; s++) begin
                en[s]   = ($urandom_range(0, 9) != 0);
                srst[s] = ($urandom_range(0, 15) == 0);
            end
            drive_random();
            step();
        end

        // Fill the pipe, then reset mid-stream.
        en = '1;
        srst = '0;
        for (int i = 0; i < 6; i++) begin
            drive_random();
            step();
        end
        chk("prereset_wb_valid", wb_valid, 1);
        do_reset();
        chk("reset_retire", retire_cnt, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_wb_valid", wb_valid, 0);
        step();
        chk("release_if_valid", if_valid, 1);
        chk("release_id_valid", id_valid, 0);
        step();
        chk("release_id_rise", id_valid, 1);

        // 17 retirements on a 4-bit counter wrap to 1.
        for (int i = 0; i < 20; i++) begin
            drive_random();
            step();
        end
        chk("wrap_retire", retire_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
